// File: rtl/rf_wb_arbiter.sv
// Write-port sequencer for the 32x64 register file: an INIT pass after reset,
// then round-robin arbitration of NREQ writeback requesters onto a registered port.
module rf_wb_arbiter #(
    parameter int unsigned     NREQ     = 2,
    parameter int unsigned     XLEN     = 64,
    parameter bit              INIT_EN  = 1'b1,
    parameter logic [XLEN-1:0] INIT_VAL = '0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*5-1:0]    req_rd,
    input  logic [NREQ*XLEN-1:0] req_data,
    output logic [NREQ-1:0]      req_ready,
    output logic                 RegWrite,
    output logic [4:0]           writereg,
    output logic [XLEN-1:0]      writeData,
    output logic                 init_done
);

    localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned RW = 5;
    localparam logic [RW-1:0] LAST_REG = 5'd31;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam state_t RST_STATE = INIT_EN ? ST_INIT : ST_RUN;

    state_t          state_q,      state_d;
    logic [RW-1:0]   init_idx_q,   init_idx_d;
    logic [PW-1:0]   rr_ptr_q,     rr_ptr_d;
    logic            reg_write_q,  reg_write_d;
    logic [RW-1:0]   write_reg_q,  write_reg_d;
    logic [XLEN-1:0] write_data_q, write_data_d;
    logic            init_done_q,  init_done_d;

    logic            gnt_found;
    logic [PW-1:0]   gnt_idx;
    logic [PW:0]     cand;
    logic [RW-1:0]   sel_rd;
    logic [XLEN-1:0] sel_data;
    logic            xfer;

    // Rotating priority scan starting at rr_ptr, wrapping modulo NREQ.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = {1'b0, rr_ptr_q} + (PW+1)'(k);
            if (cand >= (PW+1)'(NREQ)) begin
                cand = cand - (PW+1)'(NREQ);
            end
            if (!gnt_found && req_valid[cand[PW-1:0]]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand[PW-1:0];
            end
        end
    end

    // Payload of the granted requester.
    always_comb begin
        sel_rd   = '0;
        sel_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt_idx == PW'(i)) begin
                sel_rd   = req_rd[i*RW +: RW];
                sel_data = req_data[i*XLEN +: XLEN];
            end
        end
    end

    assign xfer      = (state_q == ST_RUN) && gnt_found;
    assign req_ready = xfer ? (NREQ'(1) << gnt_idx) : '0;

    always_comb begin
        state_d      = state_q;
        init_idx_d   = init_idx_q;
        rr_ptr_d     = rr_ptr_q;
        reg_write_d  = 1'b0;
        write_reg_d  = write_reg_q;
        write_data_d = write_data_q;
        init_done_d  = init_done_q;

        unique case (state_q)
            ST_INIT: begin
                reg_write_d  = 1'b1;
                write_reg_d  = init_idx_q;
                write_data_d = INIT_VAL;
                init_idx_d   = init_idx_q + RW'(1);
                if (init_idx_q == LAST_REG) begin
                    state_d     = ST_RUN;
                    init_done_d = 1'b1;
                end
            end
            ST_RUN: begin
                if (xfer) begin
                    // x0 handshakes normally but never reaches the RF.
                    reg_write_d  = (sel_rd != '0);
                    write_reg_d  = sel_rd;
                    write_data_d = sel_data;
                    rr_ptr_d     = (gnt_idx == PW'(NREQ-1)) ? '0 : gnt_idx + PW'(1);
                end
            end
            default: begin
                state_d = RST_STATE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= RST_STATE;
            init_idx_q   <= '0;
            rr_ptr_q     <= '0;
            reg_write_q  <= 1'b0;
            write_reg_q  <= '0;
            write_data_q <= '0;
            init_done_q  <= ~INIT_EN;
        end else begin
            state_q      <= state_d;
            init_idx_q   <= init_idx_d;
            rr_ptr_q     <= rr_ptr_d;
            reg_write_q  <= reg_write_d;
            write_reg_q  <= write_reg_d;
            write_data_q <= write_data_d;
            init_done_q  <= init_done_d;
        end
    end

    assign RegWrite  = reg_write_q;
    assign writereg  = write_reg_q;
    assign writeData = write_data_q;
    assign init_done = init_done_q;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Bench for rf_wb_arbiter: NREQ=2 with INIT pass, and NREQ=4 without INIT
// driven by a scoreboard model under random valid/hold traffic.
module tb_rf_wb_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: NREQ=2, INIT_EN=1, INIT_VAL=0
    logic         rst_a;
    logic [1:0]   valid_a;
    logic [9:0]   rd_a;
    logic [127:0] data_a;
    logic [1:0]   ready_a;
    logic         rw_a;
    logic [4:0]   wreg_a;
    logic [63:0]  wdata_a;
    logic         done_a;

    // Instance B: NREQ=4, INIT_EN=0
    logic         rst_b;
    logic [3:0]   valid_b;
    logic [19:0]  rd_b;
    logic [255:0] data_b;
    logic [3:0]   ready_b;
    logic         rw_b;
    logic [4:0]   wreg_b;
    logic [63:0]  wdata_b;
    logic         done_b;

    rf_wb_arbiter #(.NREQ(2), .XLEN(64), .INIT_EN(1'b1), .INIT_VAL(64'h0)) u_a (
        .clk(clk), .rst(rst_a), .req_valid(valid_a), .req_rd(rd_a), .req_data(data_a),
        .req_ready(ready_a), .RegWrite(rw_a), .writereg(wreg_a), .writeData(wdata_a),
        .init_done(done_a)
    );

    rf_wb_arbiter #(.NREQ(4), .XLEN(64), .INIT_EN(1'b0), .INIT_VAL(64'h0)) u_b (
        .clk(clk), .rst(rst_b), .req_valid(valid_b), .req_rd(rd_b), .req_data(data_b),
        .req_ready(ready_b), .RegWrite(rw_b), .writereg(wreg_b), .writeData(wdata_b),
        .init_done(done_b)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive_a(input logic [1:0] v, input logic [4:0] r0, input logic [63:0] d0,
                           input logic [4:0] r1, input logic [63:0] d1);
        valid_a = v;
        rd_a    = {r1, r0};
        data_a  = {d1, d0};
    endtask

    // Observe n INIT writes on A; requesters are held valid and must never be granted.
    task automatic init_pass(input int n, input bit chk_b);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check("init_we", 64'(rw_a), 64'd1);
            check("init_reg", 64'(wreg_a), 64'(i));
            check("init_data", wdata_a, 64'h0);
            check("init_done", 64'(done_a), 64'((i == 31) ? 1 : 0));
            if (i < 31) check("init_ready", 64'(ready_a), 64'd0);
            else        valid_a = 2'b00;
            if (chk_b) begin
                check("b_no_init_we", 64'(rw_b), 64'd0);
                check("b_init_done", 64'(done_b), 64'd1);
            end
        end
    endtask

    typedef struct packed {
        logic [1:0]  v;
        logic [4:0]  rd0;
        logic [63:0] d0;
        logic [4:0]  rd1;
        logic [63:0] d1;
        logic [1:0]  ready;
        logic        rw;
        logic [4:0]  wreg;
        logic [63:0] wdata;
    } vec_t;

    vec_t tbl [13];

    // Scoreboard for B
    typedef struct packed {
        logic        rw;
        logic [4:0]  rd;
        logic [63:0] data;
    } wr_t;

    wr_t         sbq [$];
    logic [1:0]  ptr_m;
    logic [4:0]  hold_rd;
    logic [63:0] hold_d;
    logic        pend_v  [4];
    logic [4:0]  pend_rd [4];
    logic [63:0] pend_d  [4];
    int          seq_n;

    task automatic b_pop();
        wr_t e;
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
            check("b_we", 64'(rw_b), 64'(e.rw));
            check("b_reg", 64'(wreg_b), 64'(e.rd));
            check("b_data", wdata_b, e.data);
        end
    endtask

    task automatic b_step(input bit rnd, input logic [3:0] fixed_ready, input bit use_fixed);
        logic       found;
        logic [1:0] g;
        logic [1:0] idx;
        logic [3:0] exp_rdy;
        b_pop();
        for (int i = 0; i < 4; i++) begin
            if (!pend_v[i] && (!rnd || $urandom_range(0, 2) != 0)) begin
                pend_v[i] = 1'b1;
                seq_n++;
                if (rnd) begin
                    pend_rd[i] = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
                    pend_d[i]  = {$urandom, $urandom};
                end else begin
                    pend_rd[i] = 5'(16 + i);
                    pend_d[i]  = 64'hB000_0000 + 64'(seq_n);
                end
            end
        end
        for (int i = 0; i < 4; i++) begin
            valid_b[i]        = pend_v[i];
            rd_b[i*5 +: 5]    = pend_rd[i];
            data_b[i*64 +: 64] = pend_d[i];
        end
        #1;
        found = 1'b0;
        g     = 2'd0;
        for (int k = 0; k < 4; k++) begin
            idx = ptr_m + 2'(k);
            if (!found && pend_v[idx]) begin
                found = 1'b1;
                g     = idx;
            end
        end
        exp_rdy = found ? (4'b0001 << g) : 4'b0000;
        check("b_ready", 64'(ready_b), 64'(exp_rdy));
        if (use_fixed) check("b_rot_ready", 64'(ready_b), 64'(fixed_ready));
        if (found) begin
            sbq.push_back('{rw: (pend_rd[g] != 5'd0), rd: pend_rd[g], data: pend_d[g]});
            hold_rd   = pend_rd[g];
            hold_d    = pend_d[g];
            pend_v[g] = 1'b0;
            ptr_m     = g + 2'd1;
        end else begin
            sbq.push_back('{rw: 1'b0, rd: hold_rd, data: hold_d});
        end
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        //            v      rd0    d0            rd1    d1            ready  rw    wreg   wdata
        tbl[0]  = '{2'b11, 5'd5,  64'h50,     5'd6,  64'h60,     2'b01, 1'b1, 5'd5,  64'h50};
        tbl[1]  = '{2'b11, 5'd5,  64'h51,     5'd6,  64'h60,     2'b10, 1'b1, 5'd6,  64'h60};
        tbl[2]  = '{2'b11, 5'd5,  64'h51,     5'd6,  64'h61,     2'b01, 1'b1, 5'd5,  64'h51};
        tbl[3]  = '{2'b11, 5'd5,  64'h52,     5'd6,  64'h61,     2'b10, 1'b1, 5'd6,  64'h61};
        tbl[4]  = '{2'b01, 5'd0,  64'hDEAD,   5'd0,  64'h0,      2'b01, 1'b0, 5'd0,  64'hDEAD};
        tbl[5]  = '{2'b10, 5'd0,  64'h0,      5'd31, 64'h1234,   2'b10, 1'b1, 5'd31, 64'h1234};
        tbl[6]  = '{2'b00, 5'd0,  64'h0,      5'd0,  64'h0,      2'b00, 1'b0, 5'd31, 64'h1234};
        tbl[7]  = '{2'b10, 5'd0,  64'h0,      5'd7,  64'h77,     2'b10, 1'b1, 5'd7,  64'h77};
        tbl[8]  = '{2'b10, 5'd0,  64'h0,      5'd8,  64'h88,     2'b10, 1'b1, 5'd8,  64'h88};
        tbl[9]  = '{2'b01, 5'd9,  64'h99,     5'd0,  64'h0,      2'b01, 1'b1, 5'd9,  64'h99};
        tbl[10] = '{2'b01, 5'd10, 64'hA0,     5'd0,  64'h0,      2'b01, 1'b1, 5'd10, 64'hA0};
        tbl[11] = '{2'b11, 5'd11, 64'hB0,     5'd12, 64'hC0,     2'b10, 1'b1, 5'd12, 64'hC0};
        tbl[12] = '{2'b11, 5'd11, 64'hB0,     5'd13, 64'hD0,     2'b01, 1'b1, 5'd11, 64'hB0};

        rst_a = 1'b1; rst_b = 1'b1;
        valid_a = 2'b11; rd_a = '0; data_a = '0;
        valid_b = '0; rd_b = '0; data_b = '0;
        ptr_m = 2'd0; hold_rd = '0; hold_d = '0; seq_n = 0;
        for (int i = 0; i < 4; i++) begin
            pend_v[i] = 1'b0; pend_rd[i] = '0; pend_d[i] = '0;
        end

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_we", 64'(rw_a), 64'd0);
        check("rst_reg", 64'(wreg_a), 64'd0);
        check("rst_data", wdata_a, 64'h0);
        check("rst_done", 64'(done_a), 64'd0);
        check("rst_ready", 64'(ready_a), 64'd0);
        check("b_rst_we", 64'(rw_b), 64'd0);
        check("b_rst_done", 64'(done_b), 64'd1);

        rst_a = 1'b0; rst_b = 1'b0;
        init_pass(32, 1'b1);

        for (int i = 0; i < 13; i++) begin
            drive_a(tbl[i].v, tbl[i].rd0, tbl[i].d0, tbl[i].rd1, tbl[i].d1);
            #1;
            check($sformatf("vec%0d_ready", i), 64'(ready_a), 64'(tbl[i].ready));
            @(negedge clk);
            check($sformatf("vec%0d_we", i), 64'(rw_a), 64'(tbl[i].rw));
            check($sformatf("vec%0d_reg", i), 64'(wreg_a), 64'(tbl[i].wreg));
            check($sformatf("vec%0d_data", i), wdata_a, tbl[i].wdata);
        end

        // Reset while a transfer is being handshaked: the write is discarded.
        drive_a(2'b11, 5'd3, 64'h33, 5'd4, 64'h44);
        rst_a = 1'b1;
        @(negedge clk);
        check("rst_run_we", 64'(rw_a), 64'd0);
        check("rst_run_done", 64'(done_a), 64'd0);
        check("rst_run_ready", 64'(ready_a), 64'd0);
        rst_a = 1'b0;
        init_pass(10, 1'b0);

        // Reset with init_idx=10 restarts the INIT pass from x0.
        rst_a = 1'b1;
        @(negedge clk);
        check("rst_init_we", 64'(rw_a), 64'd0);
        check("rst_init_reg", 64'(wreg_a), 64'd0);
        rst_a = 1'b0;
        valid_a = 2'b11;
        init_pass(32, 1'b0);

        // Rotation restarts at requester 0 after reset.
        drive_a(2'b11, 5'd1, 64'h11, 5'd2, 64'h22);
        #1;
        check("post_rst_ready0", 64'(ready_a), 64'd1);
        @(negedge clk);
        check("post_rst_reg0", 64'(wreg_a), 64'd1);
        drive_a(2'b10, 5'd0, 64'h0, 5'd2, 64'h22);
        #1;
        check("post_rst_ready1", 64'(ready_a), 64'd2);
        @(negedge clk);
        check("post_rst_reg1", 64'(wreg_a), 64'd2);
        check("post_rst_data1", wdata_a, 64'h22);
        valid_a = 2'b00;

        // B: all valid, strict rotation 0,1,2,3,0.
        b_step(1'b0, 4'b0001, 1'b1);
        b_step(1'b0, 4'b0010, 1'b1);
        b_step(1'b0, 4'b0100, 1'b1);
        b_step(1'b0, 4'b1000, 1'b1);
        b_step(1'b0, 4'b0001, 1'b1);

        // B: random valid/hold stress.
        for (int c = 0; c < 300; c++) begin
            b_step(1'b1, 4'b0000, 1'b0);
        end
        b_pop();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
